// File: rtl/wb_ctrl_pkg.sv
// rtl/wb_ctrl_pkg.sv - shared widths and writeback request type for the writeback controller
package wb_ctrl_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO queueing long-latency writeback results
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy next state; a push into a full queue or pop of an empty one is ignored
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    // Occupancy and pointer registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - register-file writeback arbiter with long-latency queue and busy scoreboard
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mlu_valid,
    output logic                  mlu_ready,
    input  logic [REG_ADDR_W-1:0] mlu_rd,
    input  logic [XLEN-1:0]       mlu_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  alu_stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wrdata,
    output logic                  err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    wb_req_t               fifo_din, fifo_dout, sel;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic                  sel_valid, blocked;

    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]       wrdata_q, wrdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  err_q, err_d;

    // Readiness is decided from the occupancy at the start of the cycle, not after a same-cycle pop
    assign mlu_ready = ~fifo_full;
    assign fifo_push = mlu_valid & mlu_ready;
    assign fifo_din  = '{rd: mlu_rd, data: mlu_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wb_req_t))
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ALU path always wins; the queue head drains only in cycles the ALU leaves free
    always_comb begin
        fifo_pop  = ~alu_valid & ~fifo_empty;
        sel_valid = alu_valid | fifo_pop;
        sel.rd    = alu_valid ? alu_rd : fifo_dout.rd;
        sel.data  = alu_valid ? alu_data : fifo_dout.data;
        wr_en_d   = sel_valid & (sel.rd != '0);
        wr_addr_d = sel_valid ? sel.rd : wr_addr_q;
        wrdata_d  = sel_valid ? sel.data : wrdata_q;
    end

    // Count cycles where a waiting result loses to the ALU; at the limit request a one-cycle ALU hold
    always_comb begin
        blocked  = alu_valid & (fifo_count != '0);
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (blocked) begin
            if (starve_q == STARVE_LAST) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Scoreboard: a retiring queued write clears its bit, a new issue sets it, and set wins
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop && (fifo_dout.rd != '0)) begin
            busy_d[fifo_dout.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Sticky error on an ALU write during a stall cycle or onto a register still owed a queued write
    always_comb begin
        err_d = err_q
              | (alu_valid & stall_q)
              | (alu_valid & (alu_rd != '0) & busy_q[alu_rd]);
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wrdata_q  <= '0;
            busy_q    <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wrdata_q  <= wrdata_d;
            busy_q    <= busy_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wrdata    = wrdata_q;
    assign busy      = busy_q;
    assign alu_stall = stall_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - self-checking bench for the writeback controller
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        alu_valid, mlu_valid, iss_valid;
    logic [4:0]  alu_rd, mlu_rd, iss_rd;
    logic [63:0] alu_data, mlu_data;
    logic        mlu_ready, alu_stall, wr_en, err;
    logic [31:0] busy;
    logic [4:0]  wr_addr;
    logic [63:0] wrdata;

    int n_tests = 0;
    int n_fail  = 0;

    wb_ctrl #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mlu_valid (mlu_valid),
        .mlu_ready (mlu_ready),
        .mlu_rd    (mlu_rd),
        .mlu_data  (mlu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .alu_stall (alu_stall),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wrdata    (wrdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending results plus plain bookkeeping of what the regfile port must show
    wb_req_t     mq[$];
    wb_req_t     m_head;
    logic [31:0] m_busy;
    int          m_starve, m_n0;
    logic        m_stall, m_err, m_wr_en, m_started = 1'b0;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    always @(posedge clk) begin
        if (!nrst) begin
            mq.delete();
            m_busy = '0; m_starve = 0; m_stall = 0; m_err = 0;
            m_wr_en = 0; m_addr = '0; m_data = '0;
            m_started = 1'b1;
        end else begin
            m_n0 = mq.size();
            if (alu_valid) begin
                if (m_stall) m_err = 1;
                if (alu_rd != 0 && m_busy[alu_rd]) m_err = 1;
                m_wr_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
            end else if (m_n0 > 0) begin
                m_head = mq.pop_front();
                m_wr_en = (m_head.rd != 0); m_addr = m_head.rd; m_data = m_head.data;
                if (m_head.rd != 0) m_busy[m_head.rd] = 1'b0;
                m_starve = 0;
            end else begin
                m_wr_en = 0;
            end
            m_stall = 0;
            if (alu_valid && m_n0 > 0) begin
                m_starve++;
                if (m_starve == STARVE_LIMIT) begin
                    m_stall = 1; m_starve = 0;
                end
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            if (mlu_valid && m_n0 < FIFO_DEPTH) mq.push_back('{rd: mlu_rd, data: mlu_data});
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (m_started) begin
            chk("m_wr_en",     wr_en,     m_wr_en);
            chk("m_wr_addr",   wr_addr,   m_addr);
            chk("m_wrdata",    wrdata,    m_data);
            chk("m_busy",      busy,      m_busy);
            chk("m_alu_stall", alu_stall, m_stall);
            chk("m_err",       err,       m_err);
            chk("m_mlu_ready", mlu_ready, (mq.size() < FIFO_DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mlu_valid = 0; mlu_rd = '0; mlu_data = '0;
        iss_valid = 0; iss_rd = '0;
    endtask

    initial begin
        idle();
        nrst = 0;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h1234;

        // Reset held 3 cycles with ALU traffic that must be ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wr_en", wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err, 0);
            chk("rst_ready", mlu_ready, 1);
        end
        nrst = 1; idle();
        tick();
        chk("post_rst_wr_en", wr_en, 0);
        chk("post_rst_ready", mlu_ready, 1);

        // ALU write, then an rd=0 write that must not assert wr_en
        alu_valid = 1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        chk("alu_wr_en", wr_en, 1);
        chk("alu_wr_addr", wr_addr, 5);
        chk("alu_wrdata", wrdata, 64'hDEAD_BEEF_0000_0001);
        alu_rd = 5'd0; alu_data = 64'h77;
        tick();
        chk("alu_rd0_wr_en", wr_en, 0);
        idle();
        tick();

        // Long-latency path: issue x7, then push its result
        iss_valid = 1; iss_rd = 5'd7;
        tick();
        chk("ll_busy7_set", busy[7], 1);
        iss_valid = 0; mlu_valid = 1; mlu_rd = 5'd7; mlu_data = 64'h2A;
        tick();
        chk("ll_no_write_yet", wr_en, 0);
        idle();
        tick();
        chk("ll_wr_en", wr_en, 1);
        chk("ll_wr_addr", wr_addr, 7);
        chk("ll_wrdata", wrdata, 64'h2A);
        chk("ll_busy7_clr", busy[7], 0);

        // Backpressure: ALU hogs the port while two results queue and a third is refused
        alu_valid = 1; alu_rd = 5'd10; alu_data = 64'hA0;
        mlu_valid = 1; mlu_rd = 5'd1; mlu_data = 64'h11;
        tick();
        mlu_rd = 5'd2; mlu_data = 64'h22;
        tick();
        chk("bp_ready_full", mlu_ready, 0);
        mlu_rd = 5'd3; mlu_data = 64'h33;
        tick();
        chk("bp_ready_still_full", mlu_ready, 0);
        mlu_valid = 0;
        tick();
        chk("bp_no_stall_3", alu_stall, 0);
        tick();
        chk("bp_stall", alu_stall, 1);
        alu_valid = 0;
        tick();
        chk("bp_first_addr", wr_addr, 1);
        chk("bp_first_data", wrdata, 64'h11);
        chk("bp_stall_pulse", alu_stall, 0);
        tick();
        chk("bp_second_addr", wr_addr, 2);
        chk("bp_second_data", wrdata, 64'h22);
        tick();
        chk("bp_drained", wr_en, 0);
        chk("bp_ready_again", mlu_ready, 1);

        // Same-cycle clear (pop of x9) and set (issue of x9)
        iss_valid = 1; iss_rd = 5'd9;
        tick();
        iss_valid = 0; mlu_valid = 1; mlu_rd = 5'd9; mlu_data = 64'h99;
        tick();
        mlu_valid = 0; iss_valid = 1; iss_rd = 5'd9;
        tick();
        chk("sc_busy9", busy[9], 1);
        chk("sc_wr_en", wr_en, 1);
        chk("sc_wr_addr", wr_addr, 9);
        idle();

        // WAW: ALU writes x9 while it is still owed a queued write
        alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h55;
        tick();
        chk("waw_err", err, 1);
        chk("waw_wr_en", wr_en, 1);
        chk("waw_wrdata", wrdata, 64'h55);
        idle();
        tick();
        chk("waw_sticky", err, 1);
        nrst = 0;
        tick();
        nrst = 1;
        chk("waw_err_cleared", err, 0);
        chk("waw_busy_cleared", busy, 0);

        // ALU ignores the stall request
        alu_valid = 1; alu_rd = 5'd12; alu_data = 64'hC;
        mlu_valid = 1; mlu_rd = 5'd4; mlu_data = 64'h44;
        tick();
        mlu_valid = 0;
        for (int i = 0; i < STARVE_LIMIT; i++) tick();
        chk("st_stall", alu_stall, 1);
        tick();
        chk("st_err", err, 1);
        chk("st_alu_wins", wr_addr, 12);
        alu_valid = 0;
        tick();
        chk("st_pop_addr", wr_addr, 4);
        chk("st_pop_data", wrdata, 64'h44);

        // Reset mid-operation discards a queued result
        alu_valid = 1; alu_rd = 5'd13; alu_data = 64'hD;
        mlu_valid = 1; mlu_rd = 5'd6; mlu_data = 64'h66;
        tick();
        idle();
        nrst = 0;
        tick();
        nrst = 1;
        chk("rd_err_cleared", err, 0);
        tick();
        chk("rd_discard_1", wr_en, 0);
        tick();
        chk("rd_discard_2", wr_en, 0);
        chk("rd_ready", mlu_ready, 1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
